// File: rtl/seq_matmul_int_param.sv
// Sequential signed integer matrix multiplier Z = A * B with one MAC per cycle and a stb/ack result port.
// Optional macro SEQ_MATMUL_SATURATE_EN: clamp results to the signed OUT_W range and flag z_ovf.
module seq_matmul_int_param #(
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int IDX_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    input  logic                     z_ack,
    output logic [IDX_W-1:0]         a_i,
    output logic [IDX_W-1:0]         a_j,
    output logic [IDX_W-1:0]         b_i,
    output logic [IDX_W-1:0]         b_j,
    output logic [IDX_W-1:0]         z_i,
    output logic [IDX_W-1:0]         z_j,
    output logic [OUT_W-1:0]         z_out,
    output logic                     z_stb,
    output logic                     z_ovf,
    output logic                     busy,
    output logic                     done
);
    typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;

    localparam logic [IDX_W-1:0] M_LAST = IDX_W'(M - 1);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N - 1);

    state_t                     state;
    logic [IDX_W-1:0]           i, j, k;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    sum;
    logic signed [2*DATA_W-1:0] prod;
    logic [OUT_W-1:0]           fmt_val;
    logic                       ovf_val;

    assign prod = a_in * b_in;
    assign sum  = acc + ACC_W'(prod);

`ifdef SEQ_MATMUL_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        ovf_val = 1'b0;
        fmt_val = sum[OUT_W-1:0];
        if (sum > SAT_MAX) begin
            ovf_val = 1'b1;
            fmt_val = SAT_MAX[OUT_W-1:0];
        end else if (sum < SAT_MIN) begin
            ovf_val = 1'b1;
            fmt_val = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    assign fmt_val = sum[OUT_W-1:0];
    assign ovf_val = 1'b0;
`endif

    // Storage is addressed straight from the loop counters.
    assign a_i  = i;
    assign a_j  = k;
    assign b_i  = k;
    assign b_j  = j;
    assign z_i  = i;
    assign z_j  = j;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            z_out <= '0;
            z_stb <= 1'b0;
            z_ovf <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    i     <= '0;
                    j     <= '0;
                    k     <= '0;
                    acc   <= '0;
                    state <= MAC;
                end
                MAC: if (k == K_LAST) begin
                    z_out <= fmt_val;
                    z_ovf <= ovf_val;
                    z_stb <= 1'b1;
                    k     <= '0;
                    acc   <= '0;
                    state <= OUT;
                end else begin
                    acc <= sum;
                    k   <= k + 1'b1;
                end
                OUT: if (z_stb && z_ack) begin
                    z_stb <= 1'b0;
                    if (j != N_LAST) begin
                        j     <= j + 1'b1;
                        state <= MAC;
                    end else if (i != M_LAST) begin
                        j     <= '0;
                        i     <= i + 1'b1;
                        state <= MAC;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    i     <= '0;
                    j     <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
